imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences the single-port, synchronous-read instruction memory across two phases: boot load, then run.
- Boot load: assembles a byte stream from the UART receiver into 32-bit words and writes them to instruction memory starting at address 0.
- Run: hands the memory port to the CPU fetch stage and holds the CPU in stall until the program is resident.
- Sits between uart_rx, the fetch stage and instruction_memory. Owns the memory's write_enable, address and write_data.

Parameters:
- MEM_WORDS, 16000, instruction memory depth in words; a load count above this is rejected.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- fetch_req  in  1  CPU requests an instruction read this cycle.
- fetch_addr  in  ADDR_W  CPU word address.
- fetch_valid  out  1  mem_rdata holds the word for the fetch_req of the previous cycle.
- mem_we  out  1  to instruction_memory write_enable.
- mem_addr  out  ADDR_W  to instruction_memory address.
- mem_wdata  out  32  to instruction_memory write_data.
- cpu_stall  out  1  high until load completes successfully.
- loaded  out  1  program resident; run phase active.
- load_error  out  1  sticky; load rejected.
- words_written  out  ADDR_W  number of words written so far.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=HDR, byte_cnt=0, word_cnt=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, fetch_valid=0.
  - cpu_stall=1, loaded=0, load_error=0, words_written=0.
  - Reset mid-load abandons the load. Words already written stay in memory but are not reported.
- Byte assembly:
  - Big-endian: first byte goes to [31:24], fourth byte to [7:0].
  - A 2-bit byte_cnt advances only on rx_valid and wraps 3->0.
  - rx_valid may be asserted on consecutive cycles; no byte may be lost.
- HDR:
  - Collects one 4-byte word as N = word count; only N[ADDR_W-1:0] is used.
  - On the 4th byte, the next state is chosen as follows:
    - N=0 -> DONE (or CHK, see Optional Feature).
    - N>MEM_WORDS -> ERR.
    - Otherwise -> LOAD with word_cnt=0.
- LOAD:
  - When the 4th byte of a word is accepted in cycle t, the loader drives, in cycle t+1 only: mem_we=1, mem_addr=word_cnt, mem_wdata=the assembled word.
  - word_cnt and words_written increment in cycle t+1.
  - When the write at address N-1 issues, the next state is DONE. loaded rises and cpu_stall falls in cycle t+2.
- DONE:
  - mem_we is held at 0.
  - mem_addr = fetch_addr, combinational pass-through.
  - fetch_valid = fetch_req registered one cycle, matching the memory's one-cycle read latency.
  - rx_valid is ignored.
  - fetch_valid is 0 in every state other than DONE.
- ERR:
  - load_error=1, cpu_stall=1, loaded=0, mem_we=0.
  - All input is ignored until reset.
- Outside DONE:
  - mem_addr is driven by the loader and fetch_addr is ignored.
  - fetch_req is ignored.
- No read/write collision can occur: the memory port is owned exclusively by the loader or the fetch stage according to state.

Optional Feature:
- Macro IMEM_LOAD_CHECKSUM_EN.
- When defined:
  - After the last data word (or directly after HDR if N=0), state CHK collects one further 4-byte word C.
  - C is compared with the XOR of all N loaded words; the XOR of zero words is 0.
  - Match -> DONE.
  - Mismatch -> ERR.
  - The C word is never written to memory.
- When undefined:
  - The CHK state and XOR register are absent.
  - The transition to DONE happens immediately after the last write, as described in Behaviour.

Test Plan:
- Reset, then send bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 back-to-back:
  - Write at addr 0 = 0x12345678, then addr 1 = 0x9ABCDEF0.
  - words_written=2.
  - loaded=1 and cpu_stall=0 two cycles after the final byte.
- After the load above, fetch_req=1 with fetch_addr=1 -> next cycle fetch_valid=1 and mem_rdata=0x9ABCDEF0. With fetch_req=0 -> fetch_valid=0.
- Header 00 00 3E 81 (16001 > MEM_WORDS) -> load_error=1, no mem_we ever asserted, cpu_stall stays 1, later bytes ignored.
- Header 00 00 00 00 -> loaded=1 with no writes. With IMEM_LOAD_CHECKSUM_EN, this instead requires a trailing 00 00 00 00.
- Assert rst_n=0 after 6 bytes of a 3-word load, then send a fresh 1-word load -> word written at addr 0, words_written=1, loaded=1.
- With IMEM_LOAD_CHECKSUM_EN:
  - Words 0x0000000F and 0x000000F0 with checksum 0x000000FF -> loaded=1.
  - The same words with checksum 0x000000FE -> load_error=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: turns a UART byte stream into memory writes, then
// gives the memory port to the fetch stage. Define IMEM_LOAD_CHECKSUM_EN for a trailing XOR word.
module imem_boot_loader #(
  parameter int unsigned MEM_WORDS = 16000,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              loaded,
  output logic              load_error,
  output logic [ADDR_W-1:0] words_written
);

  typedef enum logic [2:0] {
    StHdr,
    StLoad,
`ifdef IMEM_LOAD_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StErr
  } state_e;

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       shift_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              last_q;
  logic              fv_q;
  logic              stall_q;
  logic              loaded_q;
  logic              err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]       xor_q;
`endif

  logic              byte_in;
  logic              word_done;
  logic [31:0]       word;
  logic [ADDR_W-1:0] word_n;

  always_comb begin
    byte_in = rx_valid && (state_q == StHdr || state_q == StLoad
`ifdef IMEM_LOAD_CHECKSUM_EN
                           || state_q == StChk
`endif
                          );
  end

  assign word_done = byte_in && (byte_cnt_q == 2'd3);
  assign word      = {shift_q, rx_data};
  assign word_n    = word[ADDR_W-1:0];

  // Memory port belongs to the fetch stage only once the program is resident.
  assign mem_addr      = (state_q == StDone) ? fetch_addr : addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign fetch_valid   = fv_q;
  assign cpu_stall     = stall_q;
  assign loaded        = loaded_q;
  assign load_error    = err_q;
  assign words_written = word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHdr;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      n_q        <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      fv_q       <= 1'b0;
      stall_q    <= 1'b1;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      xor_q      <= 32'd0;
`endif
    end else begin
      we_q   <= 1'b0;
      last_q <= 1'b0;
      fv_q   <= (state_q == StDone) && fetch_req;
      if (byte_in) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        shift_q    <= {shift_q[15:0], rx_data};
      end
      unique case (state_q)
        StHdr: begin
          if (word_done) begin
            n_q <= word_n;
            if (word_n == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              state_q <= StChk;
`else
              state_q  <= StDone;
              loaded_q <= 1'b1;
              stall_q  <= 1'b0;
`endif
            end else if (32'(word_n) > MEM_WORDS) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              state_q    <= StLoad;
              word_cnt_q <= '0;
            end
          end
        end
        StLoad: begin
          // last_q marks the cycle in which the write to address N-1 is on the port.
          if (last_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            state_q <= StChk;
`else
            state_q  <= StDone;
            loaded_q <= 1'b1;
            stall_q  <= 1'b0;
`endif
          end
          if (word_done) begin
            we_q       <= 1'b1;
            addr_q     <= word_cnt_q;
            wdata_q    <= word;
            word_cnt_q <= word_cnt_q + ADDR_W'(1);
            last_q     <= (word_cnt_q + ADDR_W'(1)) == n_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
            xor_q      <= xor_q ^ word;
`endif
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        StChk: begin
          if (word_done) begin
            if (word == xor_q) begin
              state_q  <= StDone;
              loaded_q <= 1'b1;
              stall_q  <= 1'b0;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        StDone: ;
        StErr:  ;
        default: state_q <= StErr;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader with a behavioural memory and load model.
module tb_imem_boot_loader;
  localparam int unsigned MEM_WORDS = 16000;
  localparam int unsigned ADDR_W    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_stall;
  logic              loaded;
  logic              load_error;
  logic [ADDR_W-1:0] words_written;

  always #5 clk = ~clk;

  imem_boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_stall    (cpu_stall),
    .loaded       (loaded),
    .load_error   (load_error),
    .words_written(words_written)
  );

  // Single-port synchronous-read instruction memory.
  logic [31:0] mem_arr [0:(1<<ADDR_W)-1];
  logic [31:0] mem_rdata;
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    mem_rdata <= mem_arr[mem_addr];
  end

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                bad_fv = 0;
  always @(posedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end
  always @(negedge clk) begin
    if (rst_n && fetch_valid && !loaded) bad_fv++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]  stim_q[$];
  logic [31:0] exp_words[$];
  bit          exp_err;
  bit          exp_loaded;

  function automatic logic [31:0] word_at(int i);
    return {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
  endfunction

  // Outcome of a byte stream: header count, data words, then the optional checksum.
  function automatic void run_model();
    int unsigned n;
    logic [31:0] acc;
    exp_words.delete();
    exp_err    = 1'b0;
    exp_loaded = 1'b0;
    n = word_at(0) % (1 << ADDR_W);
    if (n > MEM_WORDS) begin
      exp_err = 1'b1;
      return;
    end
    acc = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      exp_words.push_back(word_at(i + 1));
      acc = acc ^ word_at(i + 1);
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    if (word_at(int'(n) + 1) == acc) exp_loaded = 1'b1;
    else exp_err = 1'b1;
`else
    exp_loaded = 1'b1;
`endif
  endfunction

  function automatic void push_word(logic [31:0] w);
    stim_q.push_back(w[31:24]);
    stim_q.push_back(w[23:16]);
    stim_q.push_back(w[15:8]);
    stim_q.push_back(w[7:0]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    fetch_req = 1'b0;
    #1;
    check_eq("rst_stall", 32'(cpu_stall), 32'd1);
    check_eq("rst_loaded", 32'(loaded), 32'd0);
    check_eq("rst_error", 32'(load_error), 32'd0);
    check_eq("rst_words", 32'(words_written), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_fv", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    bad_fv = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that accepts the final byte when max_gap is 0.
  task automatic send_bytes(input int unsigned max_gap, input bit noise);
    int unsigned gap;
    foreach (stim_q[i]) begin
      rx_valid = 1'b1;
      rx_data  = stim_q[i];
      if (noise) begin
        fetch_req  = 1'($urandom);
        fetch_addr = ADDR_W'($urandom);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic verify_outcome();
    repeat (3) @(posedge clk);
    #1;
    check_eq("load_error", 32'(load_error), 32'(exp_err));
    check_eq("loaded", 32'(loaded), 32'(exp_loaded));
    check_eq("cpu_stall", 32'(cpu_stall), 32'(!exp_loaded));
    check_eq("words_written", 32'(words_written), exp_words.size());
    check_eq("write_count", wr_addr_q.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < wr_addr_q.size(); i++) begin
      check_eq("write_addr", 32'(wr_addr_q[i]), i);
      check_eq("write_data", wr_data_q[i], exp_words[i]);
    end
    check_eq("fv_outside_done", bad_fv, 32'd0);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(posedge clk);
    #1;
    fetch_req  = 1'b0;
    fetch_addr = ADDR_W'($urandom);
    check_eq("fetch_valid", 32'(fetch_valid), 32'd1);
    check_eq("fetch_data", mem_rdata, exp);
  endtask

  initial begin
    int unsigned n;
    int unsigned nw;
    logic [31:0] acc;

    // Directed two-word load, back-to-back bytes.
    do_reset();
    stim_q.delete();
    push_word(32'd2);
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'h12345678 ^ 32'h9ABCDEF0);
`endif
    run_model();
    send_bytes(0, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check_eq("chk_loaded_t1", 32'(loaded), 32'd1);
`else
    check_eq("last_we_t1", 32'(mem_we), 32'd1);
    check_eq("last_addr_t1", 32'(mem_addr), 32'd1);
    check_eq("last_wdata_t1", mem_wdata, 32'h9ABCDEF0);
    check_eq("loaded_t1", 32'(loaded), 32'd0);
    @(posedge clk);
    #1;
    check_eq("loaded_t2", 32'(loaded), 32'd1);
    check_eq("stall_t2", 32'(cpu_stall), 32'd0);
    check_eq("we_t2", 32'(mem_we), 32'd0);
`endif
    verify_outcome();
    do_fetch(ADDR_W'(1), 32'h9ABCDEF0);
    @(posedge clk);
    #1;
    check_eq("fetch_idle", 32'(fetch_valid), 32'd0);
    do_fetch(ADDR_W'(0), 32'h12345678);
    stim_q.delete();
    push_word(32'hDEADBEEF);
    send_bytes(0, 1'b0);
    check_eq("done_ignores_rx", wr_addr_q.size(), 32'd2);

    // Oversize header is rejected; trailing bytes ignored.
    do_reset();
    stim_q.delete();
    push_word(32'h00003E81);
    push_word(32'h11111111);
    push_word(32'h22222222);
    run_model();
    send_bytes(1, 1'b1);
    verify_outcome();
    check_eq("oversize_err", 32'(load_error), 32'd1);

    // Empty program.
    do_reset();
    stim_q.delete();
    push_word(32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'd0);
`endif
    run_model();
    send_bytes(0, 1'b0);
    verify_outcome();
    check_eq("empty_loaded", 32'(loaded), 32'd1);

    // Reset six bytes into a three-word load, then a fresh one-word load.
    do_reset();
    stim_q.delete();
    push_word(32'd3);
    stim_q.push_back(8'hAA);
    stim_q.push_back(8'hBB);
    send_bytes(0, 1'b0);
    do_reset();
    stim_q.delete();
    push_word(32'd1);
    push_word(32'hCAFEF00D);
`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'hCAFEF00D);
`endif
    run_model();
    send_bytes(0, 1'b0);
    verify_outcome();
    do_fetch(ADDR_W'(0), 32'hCAFEF00D);

`ifdef IMEM_LOAD_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      do_reset();
      stim_q.delete();
      push_word(32'd2);
      push_word(32'h0000000F);
      push_word(32'h000000F0);
      push_word(k == 0 ? 32'h000000FF : 32'h000000FE);
      run_model();
      send_bytes(0, 1'b0);
      verify_outcome();
      check_eq("chk_dir_loaded", 32'(loaded), k == 0 ? 32'd1 : 32'd0);
    end
`endif

    // Randomized loads with gaps and fetch noise during the load.
    for (int it = 0; it < 14; it++) begin
      do_reset();
      stim_q.delete();
      if ($urandom_range(0, 4) == 0) n = $urandom_range(MEM_WORDS + 1, (1 << ADDR_W) - 1);
      else n = $urandom_range(0, 6);
      push_word({16'($urandom), 16'(n)});
      nw = (n > MEM_WORDS) ? 2 : n;
      acc = 32'd0;
      for (int i = 0; i < int'(nw); i++) begin
        logic [31:0] w;
        w = $urandom;
        acc = acc ^ w;
        push_word(w);
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      push_word(($urandom_range(0, 2) == 0) ? acc ^ (32'd1 << $urandom_range(0, 31)) : acc);
`endif
      run_model();
      send_bytes(2, 1'b1);
      verify_outcome();
      if (exp_loaded && exp_words.size() > 0) begin
        for (int f = 0; f < 3; f++) begin
          int unsigned a;
          a = $urandom_range(0, exp_words.size() - 1);
          do_fetch(ADDR_W'(a), exp_words[a]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
